// File: rtl/bcd_pkg.sv
// Shared constants and helpers for the BCD counter slice.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam int         BCD_MAX_DIGS = 8;

  function automatic logic [31:0] int_to_bcd(
    input int unsigned value,
    input int          digits
  );
    logic [31:0] r;
    int unsigned v;
    r = '0;
    v = value;
    for (int i = 0; i < BCD_MAX_DIGS; i++) begin
      if (i < digits) begin
        r[4*i +: 4] = 4'(v % 10);
        v = v / 10;
      end
    end
    return r;
  endfunction

  function automatic logic bcd_valid(input logic [31:0] vec);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < BCD_MAX_DIGS; i++) begin
      if (vec[4*i +: 4] > BCD_MAX_DIGIT) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_counter_n_digit.sv
// Single BCD digit step: increment or decrement with carry/borrow chain.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic [3:0] d,
  input  logic       up,
  input  logic       cin,
  output logic [3:0] q,
  output logic       cout
);

  always_comb begin
    q    = d;
    cout = 1'b0;
    if (cin) begin
      if (up) begin
        if (d >= BCD_MAX_DIGIT) begin
          q    = 4'd0;
          cout = 1'b1;
        end else begin
          q = d + 4'd1;
        end
      end else begin
        if (d == 4'd0) begin
          q    = BCD_MAX_DIGIT;
          cout = 1'b1;
        end else begin
          q = d - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_counter_n.sv
// N-digit BCD up/down counter with programmable modulus, load and wrap pulse.
module bcd_counter_n
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int MODULUS    = 100
) (
  input  logic                    clk_1Hz,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    up_dn,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    wrap,
  output logic                    load_err
);

  localparam int W = 4 * NUM_DIGITS;
  localparam logic [W-1:0] MAX_BCD =
    W'(int_to_bcd(MODULUS - 1, NUM_DIGITS));

  logic [W-1:0]        nxt;
  logic [NUM_DIGITS:0] chain;
  logic                load_ok;
  logic                cnt_ok;

  assign chain[0] = 1'b1;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    bcd_digit u_dig (
      .d    (count[4*g +: 4]),
      .up   (up_dn),
      .cin  (chain[g]),
      .q    (nxt[4*g +: 4]),
      .cout (chain[g+1])
    );
  end

  // BCD ordering matches decimal ordering once all digits are legal
  assign load_ok = bcd_valid(32'(load_val)) && (load_val <= MAX_BCD);
  assign cnt_ok  = bcd_valid(32'(count));

  always_ff @(posedge clk_1Hz or posedge reset) begin
    if (reset) begin
      count    <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
      if (clear) begin
        count <= '0;
      end else if (load) begin
        if (load_ok) count    <= load_val;
        else         load_err <= 1'b1;
      end else if (en) begin
        if (!cnt_ok) begin
          count <= '0;
        end else if (up_dn) begin
          if (count == MAX_BCD) begin
            count <= '0;
            wrap  <= 1'b1;
          end else begin
            count <= nxt;
          end
        end else begin
          if (count == '0) begin
            count <= MAX_BCD;
            wrap  <= 1'b1;
          end else begin
            count <= nxt;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_counter_n.sv
// Directed bench for bcd_counter_n across three parameter sets.
module tb_bcd_counter_n;

  logic        clk_1Hz = 1'b0;
  logic        reset   = 1'b1;
  logic        en      = 1'b0;
  logic        up_dn   = 1'b1;
  logic        clear   = 1'b0;
  logic        load    = 1'b0;
  logic [15:0] lv      = '0;

  logic [7:0]  c100, c60;
  logic [15:0] c4;
  logic        w100, w60, w4;
  logic        e100, e60, e4;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk_1Hz = ~clk_1Hz;

  bcd_counter_n #(.NUM_DIGITS(2), .MODULUS(100)) u_dut (
    .clk_1Hz(clk_1Hz), .reset(reset), .en(en), .up_dn(up_dn),
    .clear(clear), .load(load), .load_val(lv[7:0]),
    .count(c100), .wrap(w100), .load_err(e100)
  );

  bcd_counter_n #(.NUM_DIGITS(2), .MODULUS(60)) u_d60 (
    .clk_1Hz(clk_1Hz), .reset(reset), .en(en), .up_dn(up_dn),
    .clear(clear), .load(load), .load_val(lv[7:0]),
    .count(c60), .wrap(w60), .load_err(e60)
  );

  bcd_counter_n #(.NUM_DIGITS(4), .MODULUS(10000)) u_d4 (
    .clk_1Hz(clk_1Hz), .reset(reset), .en(en), .up_dn(up_dn),
    .clear(clear), .load(load), .load_val(lv),
    .count(c4), .wrap(w4), .load_err(e4)
  );

  typedef struct {
    logic       clr;
    logic       ld;
    logic       en;
    logic       up;
    logic [7:0] lv;
    logic [7:0] cnt;
    logic       wr;
    logic       er;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic c, input logic l, input logic e,
                       input logic u, input logic [15:0] v);
    clear = c;
    load  = l;
    en    = e;
    up_dn = u;
    lv    = v;
  endtask

  task automatic step();
    @(posedge clk_1Hz);
    #1;
  endtask

  initial begin
    tbl[0]  = '{0, 1, 0, 1, 8'h59, 8'h59, 0, 0};
    tbl[1]  = '{0, 0, 1, 1, 8'h00, 8'h00, 1, 0};
    tbl[2]  = '{0, 0, 1, 0, 8'h00, 8'h59, 1, 0};
    tbl[3]  = '{0, 0, 1, 0, 8'h00, 8'h58, 0, 0};
    tbl[4]  = '{0, 0, 1, 0, 8'h00, 8'h57, 0, 0};
    tbl[5]  = '{0, 1, 0, 1, 8'h7A, 8'h57, 0, 1};
    tbl[6]  = '{0, 1, 0, 1, 8'h65, 8'h57, 0, 1};
    tbl[7]  = '{0, 1, 0, 1, 8'h42, 8'h42, 0, 0};
    tbl[8]  = '{1, 1, 1, 1, 8'h33, 8'h00, 0, 0};
    tbl[9]  = '{0, 1, 1, 1, 8'h33, 8'h33, 0, 0};
    tbl[10] = '{0, 0, 0, 1, 8'h00, 8'h33, 0, 0};
    tbl[11] = '{0, 1, 0, 1, 8'h60, 8'h33, 0, 1};
    tbl[12] = '{0, 0, 1, 1, 8'h00, 8'h34, 0, 0};

    #2;
    check("reset_count", 32'(c100), 32'h0);
    check("reset_wrap", 32'(w100), 32'h0);
    check("reset_err", 32'(e100), 32'h0);
    step();
    reset = 1'b0;

    drive(0, 0, 1, 1, 16'h0);
    for (int i = 1; i <= 100; i++) begin
      int m;
      step();
      m = i % 100;
      check($sformatf("up100_cnt_%0d", i), 32'(c100),
            32'(((m / 10) << 4) | (m % 10)));
      check($sformatf("up100_wrap_%0d", i), 32'(w100),
            32'(i == 100));
    end

    foreach (tbl[i]) begin
      drive(tbl[i].clr, tbl[i].ld, tbl[i].en, tbl[i].up,
            {8'h00, tbl[i].lv});
      step();
      check($sformatf("m60_cnt_%0d", i), 32'(c60), 32'(tbl[i].cnt));
      check($sformatf("m60_wrap_%0d", i), 32'(w60), 32'(tbl[i].wr));
      check($sformatf("m60_err_%0d", i), 32'(e60), 32'(tbl[i].er));
    end

    drive(0, 1, 0, 1, 16'h0999); step();
    drive(0, 0, 1, 1, 16'h0);    step();
    check("d4_up_cnt", 32'(c4), 32'h1000);
    check("d4_up_wrap", 32'(w4), 32'h0);
    drive(0, 1, 0, 1, 16'h1000); step();
    drive(0, 0, 1, 0, 16'h0);    step();
    check("d4_dn_cnt", 32'(c4), 32'h0999);
    check("d4_dn_wrap", 32'(w4), 32'h0);
    drive(0, 1, 0, 1, 16'h9999); step();
    drive(0, 0, 1, 1, 16'h0);    step();
    check("d4_top_cnt", 32'(c4), 32'h0000);
    check("d4_top_wrap", 32'(w4), 32'h1);

    drive(0, 1, 0, 1, 16'h0099); step();
    drive(0, 0, 1, 1, 16'h0);    step();
    check("pre_rst_wrap", 32'(w100), 32'h1);
    drive(0, 1, 0, 1, 16'h0047); step();
    check("pre_rst_cnt", 32'(c100), 32'h47);
    drive(0, 0, 0, 1, 16'h0);
    #2 reset = 1'b1;
    #1;
    check("async_rst_cnt", 32'(c100), 32'h0);
    check("async_rst_wrap", 32'(w100), 32'h0);
    @(negedge clk_1Hz);
    reset = 1'b0;
    drive(0, 0, 1, 1, 16'h0);
    step();
    check("post_rst_cnt", 32'(c100), 32'h01);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
